// File: rtl/mips_mc_core.sv
// Multicycle MIPS subset core: a shared memory port and a datapath sequenced by a
// single FSM, with a retired-instruction counter and sticky status flags.
module mips_mc_core #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
    parameter int           CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [N-1:0]     mem_addr,
    output logic [N-1:0]     mem_wdata,
    input  logic [N-1:0]     mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_ready,
    output logic [N-1:0]     pc,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             illegal,
    output logic             ovf
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC,
        RTWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_LW  = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    state_t          state, state_next;
    logic [N-1:0]    pc_r, ir, a, b, alu_out, mdr;
    logic [N-1:0]    rf [32];
    logic [CNT_W-1:0] retired_r;
    logic            illegal_r, ovf_r, req_en;

    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd;
    logic [N-1:0]    imm_se, alu_res, diff;
    logic            funct_ok, wb_ovf, br_taken;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_se = {{(N-16){ir[15]}}, ir[15:0]};
    assign diff   = a - b;
    assign br_taken = ((opcode == OP_BEQ) && (diff == '0)) ||
                      ((opcode == OP_BNE) && (diff != '0));

    always_comb begin
        funct_ok = 1'b0;
        alu_res  = '0;
        case (funct)
            FN_ADD: begin alu_res = a + b;   funct_ok = 1'b1; end
            FN_SUB: begin alu_res = a - b;   funct_ok = 1'b1; end
            FN_AND: begin alu_res = a & b;   funct_ok = 1'b1; end
            FN_OR:  begin alu_res = a | b;   funct_ok = 1'b1; end
            FN_SLT: begin alu_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)}; funct_ok = 1'b1; end
            default: ;
        endcase
    end

    // Overflow is judged at writeback from the latched operands and ALUOut.
    always_comb begin
        wb_ovf = 1'b0;
        if (state == RTWB && funct == FN_ADD)
            wb_ovf = (a[N-1] == b[N-1]) && (alu_out[N-1] != a[N-1]);
        else if (state == RTWB && funct == FN_SUB)
            wb_ovf = (a[N-1] != b[N-1]) && (alu_out[N-1] != a[N-1]);
        else if (state == ADDIWB)
            wb_ovf = (a[N-1] == imm_se[N-1]) && (alu_out[N-1] != a[N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (req_en && mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = funct_ok ? RTEXEC : HALT;
                    OP_LW, OP_SW:  state_next = MEMADR;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_ADDI:       state_next = ADDIEX;
                    OP_J:          state_next = JUMP;
                    default:       state_next = HALT;
                endcase
            end
            MEMADR: state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWR:  if (mem_ready) state_next = FETCH;
            RTEXEC: state_next = RTWB;
            ADDIEX: state_next = ADDIWB;
            MEMWB, RTWB, ADDIWB, BRANCH, JUMP: state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // req_en keeps the port quiet for the first cycle after reset, so a request
    // in flight when reset hit is dropped rather than re-issued immediately.
    always_comb begin
        mem_read  = req_en && (state == FETCH || state == MEMRD);
        mem_write = req_en && (state == MEMWR);
        mem_addr  = (state == MEMRD || state == MEMWR) ? alu_out : pc_r;
        halted    = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) req_en <= 1'b0;
        else     req_en <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            retired_r <= '0;
            illegal_r <= 1'b0;
            ovf_r     <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: if (req_en && mem_ready) begin
                    ir   <= mem_rdata;
                    pc_r <= pc_r + N'(4);
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= pc_r + (imm_se << 2);
                    if (state_next == HALT) illegal_r <= 1'b1;
                end
                MEMADR: alu_out <= a + imm_se;
                MEMRD:  if (mem_ready) mdr <= mem_rdata;
                MEMWB: begin
                    if (rt != 5'd0) rf[rt] <= mdr;
                    retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                MEMWR: if (mem_ready) retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                RTEXEC: alu_out <= alu_res;
                ADDIEX: alu_out <= a + imm_se;
                RTWB, ADDIWB: begin
                    if (wb_ovf)
                        ovf_r <= 1'b1;
                    else if (state == RTWB && rd != 5'd0)
                        rf[rd] <= alu_out;
                    else if (state == ADDIWB && rt != 5'd0)
                        rf[rt] <= alu_out;
                    retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                BRANCH: begin
                    if (br_taken) pc_r <= alu_out;
                    retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                JUMP: begin
                    pc_r      <= {pc_r[N-1:N-4], ir[25:0], 2'b00};
                    retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = b;
    assign pc        = pc_r;
    assign retired   = retired_r;
    assign illegal   = illegal_r;
    assign ovf       = ovf_r;
endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: programs run against an instruction-level
// reference model that predicts per-instruction completion cycles and final state.
module tb_mips_mc_core;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_INS = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;
    logic        mem_read, mem_write, mem_ready;
    logic        halted, illegal, ovf;

    mips_mc_core #(.N(32), .RESET_PC(RESET_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .pc(pc), .retired(retired), .halted(halted),
        .illegal(illegal), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];
    logic [31:0] prog [$];
    int unsigned wait_tab [0:1023];
    int unsigned acc_idx;
    bit          rsp_busy;
    int unsigned rsp_w, rsp_cnt;
    logic [31:0] st_addr [$];
    logic [31:0] st_data [$];

    // reference model state and predictions
    logic [31:0] m_mem [0:255];
    logic [31:0] m_rf  [0:31];
    bit          m_ovf;
    int unsigned e_cyc [$];
    logic [31:0] e_pc  [$];
    logic [31:0] e_ret [$];
    bit          e_ill [$];
    bit          e_ovf [$];
    logic [31:0] e_st_addr [$];
    logic [31:0] e_st_data [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // memory responder: each access draws its wait-state count from wait_tab in order
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        rsp_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                if (!rsp_busy) begin
                    rsp_busy = 1'b1;
                    rsp_w    = wait_tab[acc_idx % 1024];
                    acc_idx++;
                    rsp_cnt  = 0;
                end
                mem_rdata = mem[mem_addr[9:2]];
                if (rsp_cnt < rsp_w) begin
                    mem_ready = 1'b0;
                    rsp_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    rsp_busy  = 1'b0;
                    if (mem_write === 1'b1) begin
                        mem[mem_addr[9:2]] = mem_wdata;
                        st_addr.push_back(mem_addr);
                        st_data.push_back(mem_wdata);
                    end
                end
            end else begin
                mem_ready = 1'b0;
                rsp_busy  = 1'b0;
            end
        end
    end

    task automatic set_waits(input int unsigned lo, input int unsigned hi);
        for (int i = 0; i < 1024; i++) wait_tab[i] = $urandom_range(hi, lo);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            m_mem[i] = '0;
        end
        for (int i = 0; i < prog.size(); i++) begin
            mem[i]   = prog[i];
            m_mem[i] = prog[i];
        end
        st_addr.delete();
        st_data.delete();
    endtask

    // Instruction-level model: executes until an unsupported instruction,
    // recording the cycle (from first fetch) at which each instruction ends.
    task automatic model_run();
        logic [31:0] mpc, ins, a, b, imm, res, addr, ret;
        logic [5:0]  op;
        logic [4:0]  dst;
        int unsigned cyc, acc;
        bit          ill, o, wr;
        mpc = RESET_PC; cyc = 0; acc = 0; ret = 0; m_ovf = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        e_cyc.delete(); e_pc.delete(); e_ret.delete(); e_ill.delete(); e_ovf.delete();
        e_st_addr.delete(); e_st_data.delete();
        for (int step = 0; step < 3000; step++) begin
            ins = m_mem[mpc[9:2]];
            cyc += 2 + wait_tab[acc]; acc++;
            mpc += 4;
            op  = ins[31:26];
            a   = m_rf[ins[25:21]];
            b   = m_rf[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            ill = 0; o = 0; wr = 0; res = '0; dst = '0;
            case (op)
                6'h00: begin
                    dst = ins[15:11]; wr = 1; cyc += 2;
                    case (ins[5:0])
                        6'h20: begin res = a + b; o = (a[31] == b[31]) && (res[31] != a[31]); end
                        6'h22: begin res = a - b; o = (a[31] != b[31]) && (res[31] != a[31]); end
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: begin ill = 1; wr = 0; cyc -= 2; end
                    endcase
                end
                6'h08: begin
                    dst = ins[20:16]; wr = 1; cyc += 2;
                    res = a + imm; o = (a[31] == imm[31]) && (res[31] != a[31]);
                end
                6'h23: begin
                    addr = a + imm; cyc += 3 + wait_tab[acc]; acc++;
                    dst = ins[20:16]; wr = 1; res = m_mem[addr[9:2]];
                end
                6'h2B: begin
                    addr = a + imm; cyc += 2 + wait_tab[acc]; acc++;
                    m_mem[addr[9:2]] = b;
                    e_st_addr.push_back(addr);
                    e_st_data.push_back(b);
                end
                6'h04, 6'h05: begin
                    cyc += 1;
                    if ((a == b) == (op == 6'h04)) mpc = mpc + (imm << 2);
                end
                6'h02: begin
                    cyc += 1;
                    mpc = {mpc[31:28], ins[25:0], 2'b00};
                end
                default: ill = 1;
            endcase
            if (wr) begin
                if (o) m_ovf = 1;
                else if (dst != 0) m_rf[dst] = res;
            end
            if (!ill) ret++;
            e_cyc.push_back(cyc); e_pc.push_back(mpc); e_ret.push_back(ret);
            e_ill.push_back(ill); e_ovf.push_back(m_ovf);
            if (ill) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        acc_idx = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_program(input string name);
        int unsigned t = 0;
        int unsigned k = 0;
        int unsigned guard = 0;
        logic [31:0] prev_ret = '0;
        while (mem_read !== 1'b1 && guard < 16) begin
            @(posedge clk); #1; guard++;
        end
        check({name, " first fetch"}, {31'b0, mem_read}, 32'd1);
        while (k < e_cyc.size()) begin
            check({name, " rd/wr exclusive"}, {31'b0, mem_read & mem_write}, 32'd0);
            @(posedge clk); #1; t++;
            if (t + 1 == e_cyc[k])
                check($sformatf("%s retired before #%0d", name, k), retired, prev_ret);
            if (t == e_cyc[k]) begin
                check($sformatf("%s pc #%0d", name, k), pc, e_pc[k]);
                check($sformatf("%s retired #%0d", name, k), retired, e_ret[k]);
                check($sformatf("%s illegal #%0d", name, k), {31'b0, illegal}, {31'b0, e_ill[k]});
                check($sformatf("%s halted #%0d", name, k), {31'b0, halted}, {31'b0, e_ill[k]});
                check($sformatf("%s ovf #%0d", name, k), {31'b0, ovf}, {31'b0, e_ovf[k]});
                prev_ret = e_ret[k];
                k++;
            end
        end
        for (int i = 0; i < 32; i++)
            check($sformatf("%s r%0d", name, i), dut.rf[i], m_rf[i]);
        check({name, " store count"}, st_addr.size(), e_st_addr.size());
        for (int i = 0; i < e_st_addr.size() && i < st_addr.size(); i++) begin
            check($sformatf("%s store addr %0d", name, i), st_addr[i], e_st_addr[i]);
            check($sformatf("%s store data %0d", name, i), st_data[i], e_st_data[i]);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check({name, " halted idle req"}, {31'b0, mem_read | mem_write}, 32'd0);
            check({name, " halted stays"}, {31'b0, halted}, 32'd1);
        end
    endtask

    task automatic gen_random();
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        prog.delete();
        for (int i = 0; i < 30; i++) begin
            rs = 5'($urandom_range(7, 0));
            rt = 5'($urandom_range(7, 0));
            rd = 5'($urandom_range(7, 0));
            case ($urandom_range(4, 0))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                default: fn = 6'h2A;
            endcase
            case ($urandom_range(6, 0))
                0, 1: prog.push_back(enc_i(6'h08, rs, rt, 16'($urandom)));
                2, 3: prog.push_back(enc_r(rd, rs, rt, fn));
                4: prog.push_back(enc_i(6'h2B, 5'd0, rt, 16'(32'h300 + 4 * $urandom_range(7, 0))));
                5: prog.push_back(enc_i(6'h23, 5'd0, rt, 16'(32'h300 + 4 * $urandom_range(7, 0))));
                default: prog.push_back(enc_i(($urandom_range(1, 0) != 0) ? 6'h04 : 6'h05, rs, rt, 16'd1));
            endcase
        end
        prog.push_back({6'h02, 26'(prog.size() + 2)});
        prog.push_back(HALT_INS);
        prog.push_back(HALT_INS);
    endtask

    initial begin
        int unsigned guard;
        rst = 1'b1;
        acc_idx = 0;
        set_waits(0, 0);

        // addi/addi/add with zero wait states
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd7),
                 enc_r(5'd3, 5'd1, 5'd2, 6'h20), HALT_INS};
        load_prog(); model_run(); do_reset();
        check("reset pc", pc, RESET_PC);
        check("reset retired", retired, 32'd0);
        check("reset flags", {29'b0, halted, illegal, ovf}, 32'd0);
        check("reset no request", {31'b0, mem_read | mem_write}, 32'd0);
        run_program("alu");
        check("alu r3", dut.rf[3], 32'd12);

        // store then load through a memory with two wait states per access
        set_waits(2, 2);
        prog = '{enc_i(6'h08, 5'd0, 5'd3, 16'd12), enc_i(6'h2B, 5'd0, 5'd3, 16'h0040),
                 enc_i(6'h23, 5'd0, 5'd4, 16'h0040), HALT_INS};
        load_prog(); model_run(); do_reset();
        run_program("mem");
        check("mem sw addr", (st_addr.size() > 0) ? st_addr[0] : 32'hFFFF_FFFF, 32'h40);
        check("mem sw data", (st_data.size() > 0) ? st_data[0] : 32'hFFFF_FFFF, 32'd12);
        check("mem r4", dut.rf[4], 32'd12);

        // bne taken at 0x10, beq taken, then j and a not-taken beq
        set_waits(0, 2);
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd7),
                 enc_i(6'h08, 5'd0, 5'd6, 16'd7), enc_i(6'h08, 5'd0, 5'd0, 16'd9),
                 enc_i(6'h05, 5'd1, 5'd2, 16'd2), HALT_INS, HALT_INS,
                 enc_i(6'h04, 5'd2, 5'd6, 16'd1), HALT_INS,
                 {6'h02, 26'd12}, HALT_INS, HALT_INS,
                 enc_i(6'h04, 5'd1, 5'd2, 16'd5), HALT_INS};
        load_prog(); model_run(); do_reset();
        run_program("branch");
        check("branch end pc", pc, 32'h38);

        // beq with unequal operands at 0x10 falls through to 0x14
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd7),
                 enc_i(6'h08, 5'd0, 5'd0, 16'd1), enc_i(6'h08, 5'd0, 5'd0, 16'd2),
                 enc_i(6'h04, 5'd1, 5'd2, 16'd2), HALT_INS, HALT_INS, HALT_INS};
        load_prog(); model_run(); do_reset();
        run_program("beq nt");
        check("beq nt end pc", pc, 32'h18);

        // grow $5 to 0x7FFFFFFF, then overflow on +1; execution continues
        prog = '{enc_i(6'h08, 5'd0, 5'd5, 16'h7FFF), enc_i(6'h08, 5'd0, 5'd6, 16'd1),
                 enc_i(6'h08, 5'd0, 5'd7, 16'd16),
                 enc_r(5'd5, 5'd5, 5'd5, 6'h20), enc_r(5'd5, 5'd5, 5'd6, 6'h20),
                 enc_i(6'h08, 5'd7, 5'd7, 16'hFFFF), enc_i(6'h05, 5'd7, 5'd0, 16'hFFFC),
                 enc_i(6'h08, 5'd5, 5'd5, 16'd1), enc_i(6'h08, 5'd0, 5'd8, 16'd3),
                 enc_i(6'h2B, 5'd0, 5'd5, 16'h0300), HALT_INS};
        load_prog(); model_run(); do_reset();
        run_program("ovf");
        check("ovf flag", {31'b0, ovf}, 32'd1);
        check("ovf r5 kept", dut.rf[5], 32'h7FFF_FFFF);
        check("ovf continues r8", dut.rf[8], 32'd3);

        // unsupported opcode halts
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd1), 32'hFC00_0000, enc_i(6'h08, 5'd0, 5'd2, 16'd2)};
        load_prog(); model_run(); do_reset();
        run_program("illegal");
        check("illegal flag", {31'b0, illegal}, 32'd1);
        check("illegal r2 untouched", dut.rf[2], 32'd0);

        // reset while the load is waiting in MEMRD
        set_waits(5, 5);
        prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd1), enc_i(6'h23, 5'd0, 5'd4, 16'h0040), HALT_INS};
        load_prog(); model_run(); do_reset();
        guard = 0;
        while (!(mem_read === 1'b1 && mem_addr === 32'h40) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check("rst mid-load reached", {31'b0, mem_read}, 32'd1);
        check("rst mid-load retired", retired, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst pc", pc, RESET_PC);
        check("rst requests", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst retired", retired, 32'd0);
        check("rst r1", dut.rf[1], 32'd0);
        @(negedge clk);
        acc_idx = 0;
        rst = 1'b0;
        check("rst released requests", {30'b0, mem_read, mem_write}, 32'd0);
        run_program("after rst");

        // random programs with random wait states
        for (int r = 0; r < 3; r++) begin
            set_waits(0, 3);
            gen_random();
            load_prog(); model_run(); do_reset();
            run_program($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 The module SHALL have parameter N, default 32, meaning data/address width; only 32 is supported for the MIPS instruction format.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 The module SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-004 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-006 The module SHALL have port mem_addr, output, N bits, meaning the memory byte address (PC during fetch, ALUOut during data access).
REQ-007 The module SHALL have port mem_wdata, output, N bits, meaning the store data (register B).
REQ-008 The module SHALL have port mem_rdata, input, N bits, meaning the read data, valid when mem_ready=1.
REQ-009 The module SHALL have ports mem_read and mem_write, output, 1 bit each, meaning the access request; held until mem_ready.
REQ-010 The module SHALL have port mem_ready, input, 1 bit, meaning the access completes this cycle.
REQ-011 The module SHALL have port pc, output, N bits, meaning the current program counter.
REQ-012 The module SHALL have port retired, output, CNT_W bits, meaning the count of completed instructions.
REQ-013 The module SHALL have ports halted, illegal and ovf, output, 1 bit each, meaning: core stopped, unsupported opcode seen, and sticky arithmetic overflow.

Function
REQ-014 The core SHALL execute the multicycle MIPS subset: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw (23), sw (2B), beq (04), bne (05), addi (08), j (02).
REQ-015 The internal FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, ADDIEX, ADDIWB, BRANCH, JUMP and HALT.
REQ-016 In FETCH the core SHALL assert mem_read with mem_addr=pc; on mem_ready it SHALL load IR, set pc<=pc+4 and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-017 In DECODE the core SHALL latch A/B from the regfile, set ALUOut<=pc+(signext(imm)<<2), and dispatch on opcode.
REQ-018 An unsupported opcode or funct SHALL set illegal=1 and enter HALT, with no register or memory write.
REQ-019 MEMRD and MEMWR SHALL hold mem_read or mem_write with mem_addr=ALUOut until mem_ready; MEMRD SHALL capture mem_rdata into the Data register.
REQ-020 Base latencies with zero wait states SHALL be: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3 cycles; each cycle with mem_ready=0 in a memory state SHALL add one cycle.
REQ-021 BRANCH SHALL compute A-B; it SHALL set pc<=ALUOut when (beq and zero) or (bne and not zero).
REQ-022 JUMP SHALL set pc<={pc[31:28], IR[25:0], 2'b00}.
REQ-023 Signed overflow on add, sub or addi SHALL suppress the register writeback and set ovf=1, which stays set until reset; execution SHALL continue.
REQ-024 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-025 retired SHALL increment by 1 in the last state of every completed instruction, including overflow-suppressed ones, wrapping modulo 2^CNT_W.
REQ-026 HALT SHALL be absorbing (halted=1, no memory requests) until rst.
REQ-027 mem_read and mem_write SHALL never be asserted together.

Reset
REQ-028 When rst=1 at a clock edge, the following SHALL hold regardless of the state: pc<=RESET_PC, state<=FETCH, IR/A/B/ALUOut/Data<=0, all 32 registers<=0, retired<=0, halted/illegal/ovf<=0.
REQ-029 Any in-flight memory request SHALL be dropped on reset, so that mem_read=mem_write=0 in the cycle following reset.

Verification
REQ-030 The bench SHALL check: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with mem_ready always 1 -> $3=12, retired=3 after 12 cycles.
REQ-031 The bench SHALL check: sw $3,0x40($0), then lw $4,0x40($0) with mem_ready low for 2 cycles per access -> mem_write at addr 0x40 with wdata 12, and $4=12 after 4+5+wait cycles.
REQ-032 The bench SHALL check: bne $1,$2,+2 at pc 0x10 -> pc=0x1C after 3 cycles; beq with equal operands -> taken; beq with unequal operands -> pc=0x14.
REQ-033 The bench SHALL check: addi $5,$0,0x7FFF; then a loop raising $5 to 0x7FFFFFFF and adding 1 -> ovf=1, $5 unchanged, execution continues.
REQ-034 The bench SHALL check: opcode 3F -> illegal=1 and halted=1, with no further mem_read.
REQ-035 The bench SHALL check: rst asserted mid-MEMRD -> next cycle pc=RESET_PC, requests deasserted, retired=0.
